mux2_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 2:1 data multiplexer. Accepts bursts from two independent requesters, grants the multiplexer to one at a time with round-robin fairness, and drives the select line, output data and valid/ready handshake toward a single downstream consumer. Sits directly in front of the 2:1 mux datapath and owns its select input.

---
 rtl/mux2_arbiter_if.sv | 28 ++
 rtl/mux2_arbiter.sv | 113 +++++++++++
 tb/tb_mux2_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux2_arbiter_if.sv
// Signal bundle between the two requesters, the 2:1 mux arbiter and the downstream consumer.
interface mux2_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] d0;
    logic             last0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] d1;
    logic             last1;
    logic             gnt1;
    logic             s;
    logic [WIDTH-1:0] f;
    logic             valid;
    logic             ready;
    logic             busy;

    modport slave (
        input  req0, d0, last0, req1, d1, last1, ready,
        output gnt0, gnt1, s, f, valid, busy
    );

    modport master (
        output req0, d0, last0, req1, d1, last1, ready,
        input  gnt0, gnt1, s, f, valid, busy
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter/sequencer owning the select of the shared 2:1 data mux.
// Optional burst-length preemption is enabled by defining MUX2_ARB_MAXBURST_EN.
module mux2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mux2_arbiter_if.slave bus
);
    // state  | meaning
    // IDLE   | no grant held; arbitration happens on the next edge
    // GRANT0 | requester 0 owns the mux, s=0
    // GRANT1 | requester 1 owns the mux, s=1
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    if (MAX_BEATS < 2 || MAX_BEATS > 255) begin : g_bad_max_beats
        $error("mux2_arbiter: MAX_BEATS must be within 2..255");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             sel;
    logic             sel_nxt;
    logic             last_owner;
    logic             last_owner_nxt;
    logic             grant_now;
    logic             valid_c;
    logic             accept;
    logic             last_c;
    logic             preempt;
    logic [WIDTH-1:0] f_c;

    always_comb begin
        valid_c = ((state == GRANT0) && bus.req0) || ((state == GRANT1) && bus.req1);
        accept  = valid_c && bus.ready;
        last_c  = (state == GRANT1) ? bus.last1 : bus.last0;
        f_c     = sel ? bus.d1 : bus.d0;
    end

`ifdef MUX2_ARB_MAXBURST_EN
    logic [7:0] beat_cnt;
    logic       other_req;

    // Preempt on the beat that reaches the limit, or any later beat once saturated.
    always_comb begin
        other_req = (state == GRANT1) ? bus.req0 : bus.req1;
        preempt   = other_req && (beat_cnt >= 8'(MAX_BEATS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 8'd0;
        end else if (grant_now) begin
            beat_cnt <= 8'd0;
        end else if (accept && (beat_cnt != 8'(MAX_BEATS))) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end
`else
    always_comb preempt = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        last_owner_nxt = last_owner;
        grant_now      = 1'b0;
        case (state)
            IDLE: begin
                // Tie goes to whichever requester was not granted last.
                if (bus.req0 && (!bus.req1 || last_owner)) begin
                    state_nxt      = GRANT0;
                    sel_nxt        = 1'b0;
                    last_owner_nxt = 1'b0;
                    grant_now      = 1'b1;
                end else if (bus.req1) begin
                    state_nxt      = GRANT1;
                    sel_nxt        = 1'b1;
                    last_owner_nxt = 1'b1;
                    grant_now      = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (accept && (last_c || preempt)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    assign bus.gnt0  = (state == GRANT0);
    assign bus.gnt1  = (state == GRANT1);
    assign bus.busy  = (state != IDLE);
    assign bus.s     = sel;
    assign bus.f     = f_c;
    assign bus.valid = valid_c;
endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_mux2_arbiter;
    localparam int W    = 8;
    localparam int MAXB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux2_arbiter_if #(.WIDTH(W)) bus();

    mux2_arbiter #(.WIDTH(W), .MAX_BEATS(MAXB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      q0[$];
    beat_t      q1[$];
    bit         en0;
    bit         en1;
    int         passed = 0;
    int         total  = 0;

    // Reference model: current owner (-1 none), select, requester granted last, beats this grant.
    int         owner;
    int         sel_m;
    int         last_m;
    int         cnt_m;
    int         grant_log[$];
    int         acc_log[$];
    logic [7:0] acc_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic drive();
        bus.req0  = en0 && (q0.size() > 0);
        bus.d0    = (q0.size() > 0) ? q0[0].data : 8'h00;
        bus.last0 = (q0.size() > 0) ? q0[0].last : 1'b0;
        bus.req1  = en1 && (q1.size() > 0);
        bus.d1    = (q1.size() > 0) ? q1[0].data : 8'h00;
        bus.last1 = (q1.size() > 0) ? q1[0].last : 1'b0;
    endtask

    task automatic model_reset();
        owner  = -1;
        sel_m  = 0;
        last_m = 1;
        cnt_m  = 0;
    endtask

    // One clock cycle: drive from the queues, compare at negedge, advance model, return at posedge+1.
    task automatic step();
        bit    r0;
        bit    r1;
        bit    valid_e;
        bit    acc;
        int    win;
        beat_t hd;
        drive();
        @(negedge clk);
        r0      = bus.req0;
        r1      = bus.req1;
        valid_e = (owner == 0 && r0) || (owner == 1 && r1);
        chk("gnt0",  32'(bus.gnt0),  32'(owner == 0));
        chk("gnt1",  32'(bus.gnt1),  32'(owner == 1));
        chk("busy",  32'(bus.busy),  32'(owner >= 0));
        chk("s",     32'(bus.s),     32'(sel_m));
        chk("valid", 32'(bus.valid), 32'(valid_e));
        chk("f",     32'(bus.f),     32'((sel_m != 0) ? bus.d1 : bus.d0));
        acc = valid_e && bus.ready;
        if (owner < 0) begin
            win = -1;
            if (r0 && r1) win = 1 - last_m;
            else if (r0)  win = 0;
            else if (r1)  win = 1;
            if (win >= 0) begin
                owner  = win;
                sel_m  = win;
                last_m = win;
                cnt_m  = 0;
                grant_log.push_back(win);
            end
        end else if (acc) begin
            hd = (owner == 0) ? q0.pop_front() : q1.pop_front();
            acc_log.push_back(owner);
            acc_data.push_back(hd.data);
            if (cnt_m < MAXB) cnt_m++;
            if (hd.last) owner = -1;
`ifdef MUX2_ARB_MAXBURST_EN
            else if (cnt_m >= MAXB && ((owner == 0) ? r1 : r0)) owner = -1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        en0 = 1'b0;
        en1 = 1'b0;
        drive();
        bus.d0    = 8'h5A;
        bus.d1    = 8'hA5;
        bus.ready = 1'b0;
        #1;
        chk("rst_s",     32'(bus.s),     32'd0);
        chk("rst_gnt0",  32'(bus.gnt0),  32'd0);
        chk("rst_gnt1",  32'(bus.gnt1),  32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_f",     32'(bus.f),     32'h5A);
        model_reset();
        grant_log.delete();
        acc_log.delete();
        acc_data.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && (q0.size() + q1.size()) > 0; c++) step();
        chk(tag, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        beat_t b;
        int    n0;
        model_reset();

        // Single-beat burst from requester 0.
        do_reset();
        q0.push_back('{data: 8'h3C, last: 1'b1});
        en0 = 1'b1;
        bus.ready = 1'b1;
        step();
        chk("a_gnt0", 32'(bus.gnt0), 32'd1);
        chk("a_s", 32'(bus.s), 32'd0);
        chk("a_valid", 32'(bus.valid), 32'd1);
        chk("a_f", 32'(bus.f), 32'h3C);
        step();
        chk("a_idle_busy", 32'(bus.busy), 32'd0);
        chk("a_idle_valid", 32'(bus.valid), 32'd0);
        chk("a_beats", 32'(acc_data.size()), 32'd1);
        step();

        // Both requesting single-beat bursts: strict alternation starting with 0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q0.push_back('{data: 8'(8'h10 + k), last: 1'b1});
            q1.push_back('{data: 8'(8'h20 + k), last: 1'b1});
        end
        en0 = 1'b1;
        en1 = 1'b1;
        bus.ready = 1'b1;
        drain("b_drain", 100);
        chk("b_grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < grant_log.size(); i++) chk("b_alt", 32'(grant_log[i]), 32'(i % 2));
        step();

        // Requester 1 four-beat burst with ready stalled on beat 2.
        grant_log.delete();
        acc_data.delete();
        for (int k = 0; k < 4; k++) q1.push_back('{data: 8'(8'hA1 + k), last: (k == 3)});
        en0 = 1'b0;
        en1 = 1'b1;
        bus.ready = 1'b1;
        step();
        step();
        bus.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("c_hold_f", 32'(bus.f), 32'hA2);
            chk("c_hold_valid", 32'(bus.valid), 32'd1);
            chk("c_hold_gnt1", 32'(bus.gnt1), 32'd1);
        end
        bus.ready = 1'b1;
        drain("c_drain", 20);
        chk("c_count", 32'(acc_data.size()), 32'd4);
        for (int k = 0; k < acc_data.size(); k++) chk("c_order", 32'(acc_data[k]), 32'(8'hA1 + k));
        step();

        // Reset asserted mid-burst of requester 1.
        for (int k = 0; k < 4; k++) q1.push_back('{data: 8'(8'hB1 + k), last: (k == 3)});
        step();
        step();
        chk("d_pre_gnt1", 32'(bus.gnt1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("d_rst_s", 32'(bus.s), 32'd0);
        chk("d_rst_gnt1", 32'(bus.gnt1), 32'd0);
        chk("d_rst_valid", 32'(bus.valid), 32'd0);
        chk("d_rst_busy", 32'(bus.busy), 32'd0);
        while (q1.size() > 0) begin
            b = q1.pop_front();
            if (b.last) break;
        end
        model_reset();
        grant_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q0.push_back('{data: 8'hC0, last: 1'b1});
        q1.push_back('{data: 8'hC1, last: 1'b1});
        en0 = 1'b1;
        en1 = 1'b1;
        step();
        chk("d_tie_gnt0", 32'(bus.gnt0), 32'd1);
        drain("d_drain", 20);

        // 20-beat burst from requester 0 while requester 1 waits.
        do_reset();
        for (int k = 0; k < 20; k++) q0.push_back('{data: 8'(k), last: (k == 19)});
        q1.push_back('{data: 8'hE0, last: 1'b0});
        q1.push_back('{data: 8'hE1, last: 1'b1});
        en0 = 1'b1;
        en1 = 1'b1;
        bus.ready = 1'b1;
        drain("e_drain", 200);
        n0 = 0;
        for (int i = 0; i < 20 && i < acc_log.size(); i++) if (acc_log[i] == 0) n0++;
`ifdef MUX2_ARB_MAXBURST_EN
        chk("e_first4", 32'(n0 >= 4 && acc_log[0] == 0 && acc_log[3] == 0), 32'd1);
        chk("e_preempt", 32'(acc_log[4]), 32'd1);
`else
        chk("e_no_preempt", 32'(n0), 32'd20);
        chk("e_then_1", 32'(acc_log[20]), 32'd1);
`endif

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (q0.size() == 0) begin
                int len = $urandom_range(1, 6);
                for (int k = 0; k < len; k++) q0.push_back('{data: 8'($urandom), last: (k == len - 1)});
            end
            if (q1.size() == 0) begin
                int len = $urandom_range(1, 6);
                for (int k = 0; k < len; k++) q1.push_back('{data: 8'($urandom), last: (k == len - 1)});
            end
            en0 = ($urandom_range(0, 9) < 8);
            en1 = ($urandom_range(0, 9) < 8);
            bus.ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
